// File: rtl/subleq_pc_ctrl_if.sv
// Control-strobe and program-counter status bundle between the SUBLEQ control FSM and the PC unit.
interface subleq_pc_ctrl_if #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned STEP_W      = 2,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                 en;
    logic                 branch;
    logic                 call;
    logic                 ret;
    logic [STEP_W-1:0]    step;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] pc_out;
    logic [DEPTH_W-1:0]   depth;
    logic                 stack_empty;
    logic                 stack_full;
    logic                 fault;
    logic                 halted;

    modport master (
        output en, branch, call, ret, step, addr,
        input  pc_out, depth, stack_empty, stack_full, fault, halted
    );

    modport slave (
        input  en, branch, call, ret, step, addr,
        output pc_out, depth, stack_empty, stack_full, fault, halted
    );
endinterface

// File: rtl/subleq_pc_ctrl.sv
// SUBLEQ program counter with variable step, return-address stack and sticky fault reporting.
// Define SUBLEQ_PC_HALT_DETECT_EN to freeze the unit on a self-targeting branch or call.
module subleq_pc_ctrl #(
    parameter int unsigned          WORD_SIZE    = 16,
    parameter int unsigned          STEP_W       = 2,
    parameter int unsigned          STACK_DEPTH  = 4,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
    input logic              clk,
    input logic              areset,
    subleq_pc_ctrl_if.slave  bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
`ifdef SUBLEQ_PC_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] w_pc_next;
    logic [WORD_SIZE-1:0] w_ret_addr;
    logic [DEPTH_W-1:0]   r_depth;
    logic [DEPTH_W-1:0]   w_depth_next;
    logic                 r_fault;
    logic                 w_fault_next;
    logic                 r_halted;
    logic                 w_halted_next;
    logic                 w_push;
    logic [IDX_W-1:0]     w_push_idx;
    logic [IDX_W-1:0]     w_top_idx;
    logic                 w_frozen;
    logic                 w_illegal;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_self;
    logic [WORD_SIZE-1:0] r_stack [STACK_DEPTH];

    assign w_ret_addr = r_pc + WORD_SIZE'(bus.step);
    assign w_push_idx = IDX_W'(r_depth);
    assign w_top_idx  = IDX_W'(r_depth - DEPTH_W'(1));
    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_frozen   = r_fault | r_halted;
    assign w_illegal  = (bus.branch & bus.call) | (bus.branch & bus.ret) | (bus.call & bus.ret);
    assign w_self     = (bus.addr == r_pc);

    // Next-state selection: stall, then illegal combination, then ret > call > branch > step.
    always_comb begin
        w_pc_next     = r_pc;
        w_depth_next  = r_depth;
        w_fault_next  = r_fault;
        w_halted_next = r_halted;
        w_push        = 1'b0;
        if (!w_frozen && bus.en) begin
            if (w_illegal) begin
                w_fault_next = 1'b1;
            end else if (bus.ret) begin
                if (w_empty) begin
                    w_fault_next = 1'b1;
                end else begin
                    w_pc_next    = r_stack[w_top_idx];
                    w_depth_next = r_depth - DEPTH_W'(1);
                end
            end else if (bus.call) begin
                if (w_full) begin
                    w_fault_next = 1'b1;
                end else begin
                    w_push        = 1'b1;
                    w_pc_next     = bus.addr;
                    w_depth_next  = r_depth + DEPTH_W'(1);
                    w_halted_next = HALT_EN & w_self;
                end
            end else if (bus.branch) begin
                w_pc_next     = bus.addr;
                w_halted_next = HALT_EN & w_self;
            end else begin
                w_pc_next = w_ret_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_pc     <= RESET_VECTOR;
            r_depth  <= '0;
            r_fault  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_pc_next;
            r_depth  <= w_depth_next;
            r_fault  <= w_fault_next;
            r_halted <= w_halted_next;
        end
    end

    // Stack contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_ret_addr;
        end
    end

    assign bus.pc_out      = r_pc;
    assign bus.depth       = r_depth;
    assign bus.stack_empty = w_empty;
    assign bus.stack_full  = w_full;
    assign bus.fault       = r_fault;
    assign bus.halted      = r_halted;
endmodule

// File: tb/tb_subleq_pc_ctrl.sv
// Scoreboard bench for subleq_pc_ctrl: directed vectors push expectations, a monitor compares after each update.
module tb_subleq_pc_ctrl;
`ifdef SUBLEQ_PC_HALT_DETECT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [2:0]  depth;
        logic        fault;
        logic        halted;
    } exp_t;

    logic clk = 1'b0;
    logic areset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];

    subleq_pc_ctrl_if #(.WORD_SIZE(16), .STEP_W(2), .STACK_DEPTH(4)) bus ();

    subleq_pc_ctrl #(
        .WORD_SIZE(16), .STEP_W(2), .STACK_DEPTH(4), .RESET_VECTOR(16'h0010)
    ) dut (
        .clk(clk),
        .areset(areset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, exp);
        end
    endtask

    // Monitor: every clock edge or reset assertion is an output update; compare against the oldest expectation.
    always @(posedge clk or posedge areset) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "pc", bus.pc_out, e.pc);
            chk(e.name, "depth", 16'(bus.depth), 16'(e.depth));
            chk(e.name, "fault", 16'(bus.fault), 16'(e.fault));
            chk(e.name, "halted", 16'(bus.halted), 16'(e.halted));
            chk(e.name, "empty", 16'(bus.stack_empty), 16'(e.depth == 3'd0));
            chk(e.name, "full", 16'(bus.stack_full), 16'(e.depth == 3'd4));
        end
    end

    function automatic exp_t mk(input string n, input logic [15:0] pc, input logic [2:0] d,
                                input logic f, input logic h);
        exp_t e;
        e.name = n; e.pc = pc; e.depth = d; e.fault = f; e.halted = h;
        return e;
    endfunction

    task automatic cyc(input string n, input logic en, input logic b, input logic c, input logic r,
                       input logic [1:0] st, input logic [15:0] a,
                       input logic [15:0] epc, input logic [2:0] ed, input logic ef, input logic eh);
        @(negedge clk);
        bus.en = en; bus.branch = b; bus.call = c; bus.ret = r; bus.step = st; bus.addr = a;
        sb_q.push_back(mk(n, epc, ed, ef, eh));
        @(posedge clk);
    endtask

    // Asynchronous reset between edges; the monitor samples 1 time unit after the rising reset.
    task automatic mid_reset(input string n);
        @(negedge clk);
        #2;
        bus.en = 1'b0; bus.branch = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        sb_q.push_back(mk(n, 16'h0010, 3'd0, 1'b0, 1'b0));
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.branch = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        bus.step = 2'd0; bus.addr = 16'h0000;
        @(negedge clk);
        sb_q.push_back(mk("reset", 16'h0010, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        areset = 1'b0;

        cyc("step1", 1, 0, 0, 0, 2'd3, 16'h0000, 16'h0013, 3'd0, 0, 0);
        cyc("step2", 1, 0, 0, 0, 2'd3, 16'h0000, 16'h0016, 3'd0, 0, 0);
        cyc("step3", 1, 0, 0, 0, 2'd3, 16'h0000, 16'h0019, 3'd0, 0, 0);
        cyc("step4", 1, 0, 0, 0, 2'd3, 16'h0000, 16'h001C, 3'd0, 0, 0);
        cyc("step0", 1, 0, 0, 0, 2'd0, 16'h0000, 16'h001C, 3'd0, 0, 0);
        cyc("stall_br", 0, 1, 0, 0, 2'd3, 16'h0500, 16'h001C, 3'd0, 0, 0);
        cyc("br_fffe", 1, 1, 0, 0, 2'd3, 16'hFFFE, 16'hFFFE, 3'd0, 0, 0);
        cyc("wrap", 1, 0, 0, 0, 2'd3, 16'h0000, 16'h0001, 3'd0, 0, 0);

        cyc("br_100", 1, 1, 0, 0, 2'd3, 16'h0100, 16'h0100, 3'd0, 0, 0);
        cyc("call_200", 1, 0, 1, 0, 2'd3, 16'h0200, 16'h0200, 3'd1, 0, 0);
        cyc("call_300", 1, 0, 1, 0, 2'd3, 16'h0300, 16'h0300, 3'd2, 0, 0);
        cyc("ret_1", 1, 0, 0, 1, 2'd3, 16'h0000, 16'h0203, 3'd1, 0, 0);
        cyc("stall_ret", 0, 0, 0, 1, 2'd3, 16'h0000, 16'h0203, 3'd1, 0, 0);
        cyc("ret_2", 1, 0, 0, 1, 2'd3, 16'h0000, 16'h0103, 3'd0, 0, 0);

        cyc("br_40", 1, 1, 0, 0, 2'd3, 16'h0040, 16'h0040, 3'd0, 0, 0);
        cyc("self_br", 1, 1, 0, 0, 2'd3, 16'h0040, 16'h0040, 3'd0, 0, HALT);
        cyc("after_self", 1, 0, 0, 0, 2'd3, 16'h0000, HALT ? 16'h0040 : 16'h0043, 3'd0, 0, HALT);
        mid_reset("rst_a");

        cyc("ov_c1", 1, 0, 1, 0, 2'd1, 16'h1000, 16'h1000, 3'd1, 0, 0);
        cyc("ov_c2", 1, 0, 1, 0, 2'd1, 16'h2000, 16'h2000, 3'd2, 0, 0);
        cyc("ov_c3", 1, 0, 1, 0, 2'd1, 16'h3000, 16'h3000, 3'd3, 0, 0);
        cyc("ov_c4", 1, 0, 1, 0, 2'd1, 16'h4000, 16'h4000, 3'd4, 0, 0);
        cyc("ov_c5", 1, 0, 1, 0, 2'd1, 16'h5000, 16'h4000, 3'd4, 1, 0);
        cyc("frz_br", 1, 1, 0, 0, 2'd3, 16'h0010, 16'h4000, 3'd4, 1, 0);
        cyc("frz_ret", 1, 0, 0, 1, 2'd3, 16'h0000, 16'h4000, 3'd4, 1, 0);
        mid_reset("rst_b");

        cyc("underflow", 1, 0, 0, 1, 2'd3, 16'h0000, 16'h0010, 3'd0, 1, 0);
        mid_reset("rst_c");

        cyc("br_80", 1, 1, 0, 0, 2'd3, 16'h0080, 16'h0080, 3'd0, 0, 0);
        cyc("illegal", 1, 1, 1, 0, 2'd3, 16'h0090, 16'h0080, 3'd0, 1, 0);
        mid_reset("rst_d");

        cyc("mid_c1", 1, 0, 1, 0, 2'd3, 16'h0200, 16'h0200, 3'd1, 0, 0);
        cyc("mid_c2", 1, 0, 1, 0, 2'd3, 16'h0300, 16'h0300, 3'd2, 0, 0);
        mid_reset("rst_mid");
        cyc("post_rst", 1, 0, 0, 0, 2'd3, 16'h0000, 16'h0013, 3'd0, 0, 0);
        cyc("call_700", 1, 0, 1, 0, 2'd3, 16'h0700, 16'h0700, 3'd1, 0, 0);
        cyc("ret_now", 1, 0, 0, 1, 2'd0, 16'h0000, 16'h0016, 3'd0, 0, 0);
        cyc("wrap_call", 1, 1, 0, 0, 2'd0, 16'hFFFF, 16'hFFFF, 3'd0, 0, 0);
        cyc("wc_push", 1, 0, 1, 0, 2'd2, 16'h0020, 16'h0020, 3'd1, 0, 0);
        cyc("wc_ret", 1, 0, 0, 1, 2'd0, 16'h0000, 16'h0001, 3'd0, 0, 0);

        begin
            int budget = 0;
            while (sb_q.size() > 0 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (sb_q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain pending=%0d required=0", sb_q.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
